// File: rtl/vdp99_pkg.sv
// Shared constants for the VDP99 VRAM controller: address-MSB command codes,
// default VRAM depth and the control-port phase encoding.
package vdp99_pkg;

    localparam logic [1:0] AM_READ  = 2'b00;
    localparam logic [1:0] AM_WRITE = 2'b01;
    localparam logic [1:0] AM_REG   = 2'b10;

    localparam int VRAM_SIZE_DEF = 8192;

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_e;

endpackage

// File: rtl/vram_bram.sv
// Simple dual-port VRAM: one write port, one registered read port, no reset.
// Read-before-write on a shared address returns the previous byte.
module vram_bram #(
    parameter int VRAM_SIZE = 8192,
    parameter int ADDR_W    = $clog2(VRAM_SIZE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [VRAM_SIZE];

    // Storage write and registered read in one block so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/vram_ctl.sv
// VDP99 VRAM controller: two-phase control port, read-ahead latch with CPU
// prefetch, VDP register write decode and a DMA read port that outranks prefetch.
module vram_ctl import vdp99_pkg::*; #(
    parameter  int VRAM_SIZE  = VRAM_SIZE_DEF,
    parameter  int REG_ADDR_W = 3,
    localparam int ADDR_W     = $clog2(VRAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_tick,
    input  logic                  wr_tick,
    input  logic                  mode,
    input  logic [7:0]            din,
    output logic [7:0]            cpu_dout,
    output logic                  prefetch_busy,
    output logic                  reg_wr_tick,
    output logic [REG_ADDR_W-1:0] reg_num,
    output logic [7:0]            reg_data,
    input  logic                  dma_rd_tick,
    input  logic [ADDR_W-1:0]     dma_addr,
    output logic [7:0]            dma_dout,
    output logic                  dma_valid
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

    phase_e                phase_r, phase_n_s;
    logic [ADDR_W-1:0]     addr_reg_r;
    logic [7:0]            tmp_r;
    logic [7:0]            latch_r;
    logic                  pending_r;
    logic                  inflight_r;
    logic                  reg_wr_tick_r;
    logic [REG_ADDR_W-1:0] reg_num_r;
    logic [7:0]            reg_data_r;
    logic                  dma_valid_r;
    logic [7:0]            rd_data_s;
    logic [ADDR_W-1:0]     rd_addr_s;
    logic [ADDR_W-1:0]     load_addr_s;

    logic ctrl_wr_s, ctrl_rd_s, data_wr_s, data_rd_s;
    logic tmp_load_s, addr_load_s, read_setup_s, reg_wr_s, launch_s;

    // A simultaneous write strobe suppresses the read strobe
    assign ctrl_wr_s   = wr_tick & mode;
    assign data_wr_s   = wr_tick & ~mode;
    assign ctrl_rd_s   = rd_tick & ~wr_tick & mode;
    assign data_rd_s   = rd_tick & ~wr_tick & ~mode;
    assign load_addr_s = ADDR_W'({din[5:0], tmp_r});

    // Prefetch launches only on an otherwise quiet cycle so it never reads a stale address
    assign launch_s  = pending_r & ~dma_rd_tick & ~data_wr_s & ~data_rd_s & ~addr_load_s;
    assign rd_addr_s = dma_rd_tick ? dma_addr : addr_reg_r;

    // Control-port phase state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r <= PH_FIRST;
        end else begin
            phase_r <= phase_n_s;
        end
    end

    // Control-port phase next state; a control read resynchronises to the first byte
    always_comb begin
        phase_n_s = phase_r;
        if (ctrl_wr_s) begin
            phase_n_s = (phase_r == PH_FIRST) ? PH_SECOND : PH_FIRST;
        end else if (ctrl_rd_s) begin
            phase_n_s = PH_FIRST;
        end else begin
            phase_n_s = phase_r;
        end
    end

    // Control-port command decode
    always_comb begin
        tmp_load_s   = 1'b0;
        addr_load_s  = 1'b0;
        read_setup_s = 1'b0;
        reg_wr_s     = 1'b0;
        if (ctrl_wr_s) begin
            case (phase_r)
                PH_FIRST: tmp_load_s = 1'b1;
                PH_SECOND: begin
                    case (din[7:6])
                        AM_READ: begin
                            addr_load_s  = 1'b1;
                            read_setup_s = 1'b1;
                        end
                        AM_WRITE: addr_load_s = 1'b1;
                        AM_REG:   reg_wr_s    = 1'b1;
                        default:  reg_wr_s    = 1'b0;
                    endcase
                end
                default: tmp_load_s = 1'b0;
            endcase
        end else begin
            tmp_load_s = 1'b0;
        end
    end

    // Address counter, latch, prefetch tracking and registered side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg_r    <= '0;
            tmp_r         <= 8'h00;
            latch_r       <= 8'h00;
            pending_r     <= 1'b0;
            inflight_r    <= 1'b0;
            reg_wr_tick_r <= 1'b0;
            reg_num_r     <= '0;
            reg_data_r    <= 8'h00;
            dma_valid_r   <= 1'b0;
        end else begin
            if (tmp_load_s) begin
                tmp_r <= din;
            end
            if (data_wr_s || data_rd_s) begin
                addr_reg_r <= addr_reg_r + ADDR_ONE;
            end else if (addr_load_s) begin
                addr_reg_r <= load_addr_s;
            end
            if (data_wr_s) begin
                pending_r <= 1'b0;
            end else if (addr_load_s) begin
                pending_r <= read_setup_s;
            end else if (data_rd_s) begin
                pending_r <= 1'b1;
            end else if (launch_s) begin
                pending_r <= 1'b0;
            end
            inflight_r <= launch_s;
            // A write or address load in the return cycle discards the prefetched byte
            if (data_wr_s) begin
                latch_r <= din;
            end else if (inflight_r && !addr_load_s) begin
                latch_r <= rd_data_s;
            end
            reg_wr_tick_r <= reg_wr_s;
            if (reg_wr_s) begin
                reg_num_r  <= din[REG_ADDR_W-1:0];
                reg_data_r <= tmp_r;
            end
            dma_valid_r <= dma_rd_tick;
        end
    end

    vram_bram #(
        .VRAM_SIZE (VRAM_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .we    (data_wr_s),
        .waddr (addr_reg_r),
        .wdata (din),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    assign cpu_dout      = latch_r;
    assign prefetch_busy = pending_r | inflight_r;
    assign reg_wr_tick   = reg_wr_tick_r;
    assign reg_num       = reg_num_r;
    assign reg_data      = reg_data_r;
    assign dma_valid     = dma_valid_r;
    // The RAM output register is unreset, so gate it to keep dma_dout at zero after reset
    assign dma_dout      = dma_valid_r ? rd_data_s : 8'h00;

endmodule

// File: tb/tb_vram_ctl.sv
// Directed bench for vram_ctl: control-port decode, prefetch timing, DMA
// arbitration, address wrap and asynchronous reset during a prefetch.
module tb_vram_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_tick = 1'b0;
    logic        wr_tick = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  cpu_dout;
    logic        prefetch_busy;
    logic        reg_wr_tick;
    logic [2:0]  reg_num;
    logic [7:0]  reg_data;
    logic        dma_rd_tick = 1'b0;
    logic [12:0] dma_addr = 13'h0000;
    logic [7:0]  dma_dout;
    logic        dma_valid;

    int total = 0;
    int fails = 0;

    vram_ctl dut (
        .clk           (clk),
        .reset         (reset),
        .rd_tick       (rd_tick),
        .wr_tick       (wr_tick),
        .mode          (mode),
        .din           (din),
        .cpu_dout      (cpu_dout),
        .prefetch_busy (prefetch_busy),
        .reg_wr_tick   (reg_wr_tick),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .dma_rd_tick   (dma_rd_tick),
        .dma_addr      (dma_addr),
        .dma_dout      (dma_dout),
        .dma_valid     (dma_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ctl_wr(input logic [7:0] d);
        wr_tick = 1'b1; mode = 1'b1; din = d;
        step();
        wr_tick = 1'b0; mode = 1'b0;
    endtask

    task automatic data_wr(input logic [7:0] d);
        wr_tick = 1'b1; mode = 1'b0; din = d;
        step();
        wr_tick = 1'b0;
    endtask

    task automatic data_rd();
        rd_tick = 1'b1; mode = 1'b0;
        step();
        rd_tick = 1'b0;
    endtask

    task automatic ctl_rd();
        rd_tick = 1'b1; mode = 1'b1;
        step();
        rd_tick = 1'b0; mode = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk8("rst_cpu_dout", cpu_dout, 8'h00);
        chk1("rst_busy", prefetch_busy, 1'b0);
        chk1("rst_reg_tick", reg_wr_tick, 1'b0);
        chk8("rst_reg_num", {5'b0, reg_num}, 8'h00);
        chk8("rst_reg_data", reg_data, 8'h00);
        chk8("rst_dma_dout", dma_dout, 8'h00);
        chk1("rst_dma_valid", dma_valid, 1'b0);
        reset = 1'b0;
        step();

        // Write setup 0x1234, two data writes
        ctl_wr(8'h34); ctl_wr(8'h52);
        data_wr(8'hAA); data_wr(8'hBB);
        chk8("wr_cpu_dout", cpu_dout, 8'hBB);
        chk1("wr_busy", prefetch_busy, 1'b0);

        // Read setup 0x1234: busy for two cycles, then latch = mem[0x1234]
        ctl_wr(8'h34); ctl_wr(8'h12);
        chk1("rs_busy0", prefetch_busy, 1'b1);
        step();
        chk1("rs_busy1", prefetch_busy, 1'b1);
        step();
        chk1("rs_busy2", prefetch_busy, 1'b0);
        chk8("rs_latch", cpu_dout, 8'hAA);
        data_rd();
        chk8("rd_stale", cpu_dout, 8'hAA);
        chk1("rd_busy", prefetch_busy, 1'b1);
        step(); step();
        chk8("rd_refill", cpu_dout, 8'hBB);
        chk1("rd_busy_done", prefetch_busy, 1'b0);

        // Register write: value 0x07 to register 5
        ctl_wr(8'h07); ctl_wr(8'h85);
        chk1("reg_tick", reg_wr_tick, 1'b1);
        chk8("reg_num", {5'b0, reg_num}, 8'h05);
        chk8("reg_data", reg_data, 8'h07);
        step();
        chk1("reg_tick_off", reg_wr_tick, 1'b0);
        // Address still 0x1235 after the register write
        data_wr(8'hCC);

        // Phase resync via control read, then write setup 0x1FFF and wrap
        ctl_wr(8'h00); ctl_rd();
        ctl_wr(8'hFF); ctl_wr(8'h5F);
        data_wr(8'h11);
        data_wr(8'h22); data_wr(8'h33); data_wr(8'h44); data_wr(8'h55);
        chk8("wrap_cpu_dout", cpu_dout, 8'h55);
        chk1("wrap_busy", prefetch_busy, 1'b0);

        // Read setup 0x1FFF while DMA reads 0x0000..0x0003 for four cycles
        ctl_wr(8'hFF);
        wr_tick = 1'b1; mode = 1'b1; din = 8'h1F;
        dma_rd_tick = 1'b1; dma_addr = 13'h0000;
        step();
        wr_tick = 1'b0; mode = 1'b0;
        chk1("dma0_valid", dma_valid, 1'b1);
        chk8("dma0_dout", dma_dout, 8'h22);
        dma_addr = 13'h0001;
        step();
        chk8("dma1_dout", dma_dout, 8'h33);
        chk1("dma1_busy", prefetch_busy, 1'b1);
        dma_addr = 13'h0002;
        step();
        chk8("dma2_dout", dma_dout, 8'h44);
        dma_addr = 13'h0003;
        step();
        chk1("dma3_valid", dma_valid, 1'b1);
        chk8("dma3_dout", dma_dout, 8'h55);
        chk1("dma3_busy", prefetch_busy, 1'b1);
        dma_rd_tick = 1'b0;
        step();
        chk1("dma_end_valid", dma_valid, 1'b0);
        chk1("pf_after_dma1", prefetch_busy, 1'b1);
        step();
        chk1("pf_after_dma2", prefetch_busy, 1'b0);
        chk8("pf_wrap_byte", cpu_dout, 8'h11);

        // Same-cycle write and DMA read to 0x0000 returns the old byte
        ctl_wr(8'h00); ctl_wr(8'h40);
        wr_tick = 1'b1; mode = 1'b0; din = 8'h99;
        dma_rd_tick = 1'b1; dma_addr = 13'h0000;
        step();
        wr_tick = 1'b0;
        chk8("dma_old_byte", dma_dout, 8'h22);
        step();
        chk8("dma_new_byte", dma_dout, 8'h99);
        dma_addr = 13'h1235;
        step();
        chk8("dma_reg_keep_addr", dma_dout, 8'hCC);
        dma_rd_tick = 1'b0;

        // Write and read strobes together: the write wins
        wr_tick = 1'b1; rd_tick = 1'b1; mode = 1'b0; din = 8'h66;
        step();
        wr_tick = 1'b0; rd_tick = 1'b0;
        chk8("wr_rd_latch", cpu_dout, 8'h66);
        chk1("wr_rd_busy", prefetch_busy, 1'b0);

        // Reset in the middle of a prefetch
        ctl_wr(8'h35); ctl_wr(8'h12);
        step();
        chk1("mid_busy", prefetch_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk8("mr_cpu_dout", cpu_dout, 8'h00);
        chk1("mr_busy", prefetch_busy, 1'b0);
        chk8("mr_reg_num", {5'b0, reg_num}, 8'h00);
        chk8("mr_reg_data", reg_data, 8'h00);
        chk1("mr_dma_valid", dma_valid, 1'b0);
        chk8("mr_dma_dout", dma_dout, 8'h00);
        step();
        reset = 1'b0;
        step(); step();
        chk8("post_rst_latch", cpu_dout, 8'h00);
        chk1("post_rst_busy", prefetch_busy, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
